// File: rtl/systolic_pkg.sv
// Shared types and elaboration-time helpers for the systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  // Accumulator width: full product plus K-fold growth plus one guard bit.
  function automatic int unsigned calc_obits(input int unsigned i_bits, input int unsigned k_depth);
    return 2 * i_bits + $clog2(k_depth) + 1;
  endfunction

  // Cycles the drain counter covers before results are declared final.
  function automatic int unsigned drain_len(input int unsigned size);
    return 3 * size - 2;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// Job/result handshake bundle for systolic_mm_engine; master drives jobs, slave is the engine.
interface systolic_mm_engine_if
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned I_BITS  = 8,
  parameter int unsigned K_DEPTH = 8,
  parameter int unsigned O_BITS  = calc_obits(I_BITS, K_DEPTH)
);

  logic                            i_start;
  logic                            i_acc_mode;
  logic                            i_valid;
  logic                            o_ready;
  logic [SIZE*I_BITS-1:0]          i_a_full;
  logic [SIZE*I_BITS-1:0]          i_b_full;
  logic [SIZE*SIZE*O_BITS-1:0]     o_c_full;
  logic                            o_c_valid;
  logic                            i_c_ready;
  logic                            o_busy;
  logic [$clog2(K_DEPTH+1)-1:0]    o_beat_cnt;

  modport master (
    output i_start, i_acc_mode, i_valid, i_a_full, i_b_full, i_c_ready,
    input  o_ready, o_c_full, o_c_valid, o_busy, o_beat_cnt
  );

  modport slave (
    input  i_start, i_acc_mode, i_valid, i_a_full, i_b_full, i_c_ready,
    output o_ready, o_c_full, o_c_valid, o_busy, o_beat_cnt
  );

endinterface

// File: rtl/systolic_pe.sv
// One processing element: registered a/b/valid pass-through plus a clearable MAC.
module systolic_pe #(
  parameter int unsigned I_BITS = 8,
  parameter int unsigned O_BITS = 19,
  parameter bit          SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [I_BITS-1:0] a_in,
  input  logic              a_vld_in,
  input  logic [I_BITS-1:0] b_in,
  input  logic              b_vld_in,
  output logic [I_BITS-1:0] a_out,
  output logic              a_vld_out,
  output logic [I_BITS-1:0] b_out,
  output logic              b_vld_out,
  output logic [O_BITS-1:0] acc
);

  logic [2*I_BITS-1:0] a_x;
  logic [2*I_BITS-1:0] b_x;
  logic [2*I_BITS-1:0] prod;
  logic [O_BITS-1:0]   prod_ext;

  // Extending operands to the product width makes one multiplier serve both modes.
  assign a_x      = {{I_BITS{SIGNED && a_in[I_BITS-1]}}, a_in};
  assign b_x      = {{I_BITS{SIGNED && b_in[I_BITS-1]}}, b_in};
  assign prod     = a_x * b_x;
  assign prod_ext = {{(O_BITS-2*I_BITS){SIGNED && prod[2*I_BITS-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
      if (clear)
        acc <= '0;
      else if (a_vld_in && b_vld_in)
        acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// SIZE x SIZE output-stationary systolic array computing C (+)= A*B over K_DEPTH streamed beats.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned I_BITS  = 8,
  parameter int unsigned K_DEPTH = 8,
  parameter int unsigned O_BITS  = calc_obits(I_BITS, K_DEPTH),
  parameter bit          SIGNED  = 1'b0
) (
  input logic                i_clock,
  input logic                i_reset,
  systolic_mm_engine_if.slave bus
);

  localparam int unsigned CNT_W        = $clog2(K_DEPTH + 1);
  localparam int unsigned DRAIN_CYCLES = drain_len(SIZE);
  localparam int unsigned DRN_W        = $clog2(DRAIN_CYCLES + 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   beat_cnt;
  logic [DRN_W-1:0]   drain_cnt;
  logic               ready;
  logic               busy;
  logic               c_valid;
  logic               xfer;
  logic               last_beat;
  logic               start_go;
  logic               clear_acc;

  logic [I_BITS-1:0]  a_h  [SIZE][SIZE+1];
  logic               av_h [SIZE][SIZE+1];
  logic [I_BITS-1:0]  b_v  [SIZE+1][SIZE];
  logic               bv_v [SIZE+1][SIZE];
  logic [SIZE*SIZE*O_BITS-1:0] c_full;

  assign xfer      = bus.i_valid && ready;
  assign last_beat = xfer && (beat_cnt == CNT_W'(K_DEPTH - 1));
  assign start_go  = bus.i_start && ((state == IDLE) || ((state == DONE) && bus.i_c_ready));
  assign clear_acc = start_go && !bus.i_acc_mode;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_go) state_next = LOAD;
      LOAD:    if (last_beat) state_next = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_next = DONE;
      DONE:    if (bus.i_c_ready) state_next = bus.i_start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready   = (state == LOAD);
    busy    = (state == LOAD) || (state == DRAIN);
    c_valid = (state == DONE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_go)  beat_cnt <= '0;
      else if (xfer) beat_cnt <= beat_cnt + 1'b1;
      if (last_beat)
        drain_cnt <= DRN_W'(DRAIN_CYCLES);
      else if ((state == DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Each skew line has r+1 stages: one capture register plus r cycles of stagger.
  for (genvar r = 0; r < SIZE; r++) begin : g_skew
    logic [I_BITS-1:0] a_q [r+1];
    logic              a_v [r+1];
    logic [I_BITS-1:0] b_q [r+1];
    logic              b_q_v [r+1];
    for (genvar d = 0; d <= r; d++) begin : g_stage
      always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
          a_q[d]   <= '0;
          a_v[d]   <= 1'b0;
          b_q[d]   <= '0;
          b_q_v[d] <= 1'b0;
        end else if (d == 0) begin
          a_q[d]   <= xfer ? bus.i_a_full[r*I_BITS +: I_BITS] : '0;
          a_v[d]   <= xfer;
          b_q[d]   <= xfer ? bus.i_b_full[r*I_BITS +: I_BITS] : '0;
          b_q_v[d] <= xfer;
        end else begin
          a_q[d]   <= a_q[(d == 0) ? 0 : d-1];
          a_v[d]   <= a_v[(d == 0) ? 0 : d-1];
          b_q[d]   <= b_q[(d == 0) ? 0 : d-1];
          b_q_v[d] <= b_q_v[(d == 0) ? 0 : d-1];
        end
      end
    end
    assign a_h[r][0]  = a_q[r];
    assign av_h[r][0] = a_v[r];
    assign b_v[0][r]  = b_q[r];
    assign bv_v[0][r] = b_q_v[r];
  end

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      systolic_pe #(
        .I_BITS (I_BITS),
        .O_BITS (O_BITS),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk       (i_clock),
        .rst_n     (i_reset),
        .clear     (clear_acc),
        .a_in      (a_h[r][c]),
        .a_vld_in  (av_h[r][c]),
        .b_in      (b_v[r][c]),
        .b_vld_in  (bv_v[r][c]),
        .a_out     (a_h[r][c+1]),
        .a_vld_out (av_h[r][c+1]),
        .b_out     (b_v[r+1][c]),
        .b_vld_out (bv_v[r+1][c]),
        .acc       (c_full[(r*SIZE+c)*O_BITS +: O_BITS])
      );
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_busy     = busy;
  assign bus.o_c_valid  = c_valid;
  assign bus.o_beat_cnt = beat_cnt;
  assign bus.o_c_full   = c_full;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Drives an unsigned and a signed engine with identical jobs and checks both against a matrix model.
module tb_systolic_mm_engine;
  import systolic_pkg::*;

  localparam int unsigned SIZE    = 4;
  localparam int unsigned I_BITS  = 8;
  localparam int unsigned K_DEPTH = 4;
  localparam int unsigned O_BITS  = 19;
  localparam int unsigned CW      = SIZE * SIZE * O_BITS;
  localparam int          LAT     = 3 * SIZE - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   start = 1'b0;
  logic                   acc_mode = 1'b0;
  logic                   valid = 1'b0;
  logic                   c_ready = 1'b0;
  logic [SIZE*I_BITS-1:0] a_full = '0;
  logic [SIZE*I_BITS-1:0] b_full = '0;

  systolic_mm_engine_if #(.SIZE(SIZE), .I_BITS(I_BITS), .K_DEPTH(K_DEPTH), .O_BITS(O_BITS)) if_u ();
  systolic_mm_engine_if #(.SIZE(SIZE), .I_BITS(I_BITS), .K_DEPTH(K_DEPTH), .O_BITS(O_BITS)) if_s ();

  assign if_u.i_start = start;      assign if_s.i_start = start;
  assign if_u.i_acc_mode = acc_mode; assign if_s.i_acc_mode = acc_mode;
  assign if_u.i_valid = valid;      assign if_s.i_valid = valid;
  assign if_u.i_a_full = a_full;    assign if_s.i_a_full = a_full;
  assign if_u.i_b_full = b_full;    assign if_s.i_b_full = b_full;
  assign if_u.i_c_ready = c_ready;  assign if_s.i_c_ready = c_ready;

  systolic_mm_engine #(.SIZE(SIZE), .I_BITS(I_BITS), .K_DEPTH(K_DEPTH), .O_BITS(O_BITS), .SIGNED(1'b0))
    u_dut_u (.i_clock(clk), .i_reset(rst_n), .bus(if_u));
  systolic_mm_engine #(.SIZE(SIZE), .I_BITS(I_BITS), .K_DEPTH(K_DEPTH), .O_BITS(O_BITS), .SIGNED(1'b1))
    u_dut_s (.i_clock(clk), .i_reset(rst_n), .bus(if_s));

  logic [I_BITS-1:0] mat_a [SIZE][K_DEPTH];
  logic [I_BITS-1:0] mat_b [K_DEPTH][SIZE];
  logic [O_BITS-1:0] exp_u [SIZE][SIZE];
  logic [O_BITS-1:0] exp_s [SIZE][SIZE];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_clear();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        exp_u[r][c] = '0;
        exp_s[r][c] = '0;
      end
  endtask

  task automatic model_job(input bit accm);
    logic signed [63:0] su, ss;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        su = 0;
        ss = 0;
        for (int k = 0; k < K_DEPTH; k++) begin
          su = su + longint'(mat_a[r][k]) * longint'(mat_b[k][c]);
          ss = ss + longint'($signed(mat_a[r][k])) * longint'($signed(mat_b[k][c]));
        end
        if (!accm) begin
          exp_u[r][c] = '0;
          exp_s[r][c] = '0;
        end
        exp_u[r][c] = exp_u[r][c] + su[O_BITS-1:0];
        exp_s[r][c] = exp_s[r][c] + ss[O_BITS-1:0];
      end
  endtask

  function automatic logic [CW-1:0] pack_exp(input bit sgn);
    logic [CW-1:0] v;
    v = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        v[(r*SIZE+c)*O_BITS +: O_BITS] = sgn ? exp_s[r][c] : exp_u[r][c];
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < K_DEPTH; k++) begin
        mat_a[i][k] = I_BITS'($urandom);
        mat_b[k][i] = I_BITS'($urandom);
      end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < K_DEPTH; k++) begin
        mat_a[i][k] = (i == k) ? 8'd1 : 8'd0;
        mat_b[k][i] = I_BITS'(k * SIZE + i + 1);
      end
  endtask

  task automatic fill_const(input logic [I_BITS-1:0] av, input logic [I_BITS-1:0] bv);
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < K_DEPTH; k++) begin
        mat_a[i][k] = av;
        mat_b[k][i] = bv;
      end
  endtask

  // vmode: 0 = valid held high, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic run_job(input bit accm, input bit skip_start, input int vmode, input int hold,
                         input bit drain_start, input bit b2b);
    int idx, cyc, lat;
    bit v;
    logic [CW-1:0] eu, es;
    model_job(accm);
    eu = pack_exp(1'b0);
    es = pack_exp(1'b1);
    if (!skip_start) begin
      start = 1'b1;
      acc_mode = accm;
      @(posedge clk); #1;
      start = 1'b0;
      acc_mode = 1'b0;
      n_checks++;
      if (if_u.o_ready !== 1'b1 || if_u.o_busy !== 1'b1 || if_u.o_beat_cnt !== 3'd0 ||
          if_s.o_ready !== 1'b1 || if_s.o_beat_cnt !== 3'd0)
        $display("FAIL job_start: ready=%b busy=%b beat=%0d, required 1 1 0",
                 if_u.o_ready, if_u.o_busy, if_u.o_beat_cnt);
      else n_pass++;
    end
    idx = 0;
    cyc = 0;
    while (idx < K_DEPTH && cyc < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = bit'($urandom_range(0, 1));
      endcase
      valid = v;
      if (v) begin
        for (int i = 0; i < SIZE; i++) begin
          a_full[i*I_BITS +: I_BITS] = mat_a[i][idx];
          b_full[i*I_BITS +: I_BITS] = mat_b[idx][i];
        end
      end else begin
        a_full = $urandom;
        b_full = $urandom;
      end
      @(posedge clk); #1;
      if (v) idx++;
      cyc++;
      if (idx < K_DEPTH) begin
        n_checks++;
        if (if_u.o_beat_cnt !== 3'(idx) || if_s.o_beat_cnt !== 3'(idx) || if_u.o_ready !== 1'b1)
          $display("FAIL beat_count: beat=%0d ready=%b, required %0d 1", if_u.o_beat_cnt, if_u.o_ready, idx);
        else n_pass++;
      end
    end
    valid = 1'b0;
    n_checks++;
    if (if_u.o_ready !== 1'b0 || if_s.o_ready !== 1'b0 || if_u.o_busy !== 1'b1 ||
        if_u.o_beat_cnt !== 3'(K_DEPTH) || idx != K_DEPTH)
      $display("FAIL load_exit: ready=%b busy=%b beat=%0d accepted=%0d, required 0 1 %0d %0d",
               if_u.o_ready, if_u.o_busy, if_u.o_beat_cnt, idx, K_DEPTH, K_DEPTH);
    else n_pass++;
    lat = 0;
    while (if_u.o_c_valid !== 1'b1 && lat < 100) begin
      start = drain_start && (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (lat != LAT || if_s.o_c_valid !== 1'b1)
      $display("FAIL result_latency: got %0d cycles (signed valid=%b), required %0d", lat, if_s.o_c_valid, LAT);
    else n_pass++;
    n_checks++;
    if (if_u.o_c_full !== eu)
      $display("FAIL c_unsigned: got %h, required %h", if_u.o_c_full, eu);
    else n_pass++;
    n_checks++;
    if (if_s.o_c_full !== es)
      $display("FAIL c_signed: got %h, required %h", if_s.o_c_full, es);
    else n_pass++;
    n_checks++;
    if (if_u.o_busy !== 1'b0 || if_u.o_beat_cnt !== 3'(K_DEPTH))
      $display("FAIL done_flags: busy=%b beat=%0d, required 0 %0d", if_u.o_busy, if_u.o_beat_cnt, K_DEPTH);
    else n_pass++;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_checks++;
      if (if_u.o_c_valid !== 1'b1 || if_s.o_c_valid !== 1'b1 || if_u.o_c_full !== eu || if_s.o_c_full !== es)
        $display("FAIL done_hold: valid=%b/%b, c_u=%h, required valid 1 and c_u=%h",
                 if_u.o_c_valid, if_s.o_c_valid, if_u.o_c_full, eu);
      else n_pass++;
    end
    c_ready = 1'b1;
    if (b2b) begin
      start = 1'b1;
      acc_mode = 1'b0;
    end
    @(posedge clk); #1;
    c_ready = 1'b0;
    start = 1'b0;
    n_checks++;
    if (b2b) begin
      if (if_u.o_c_valid !== 1'b0 || if_u.o_busy !== 1'b1 || if_u.o_ready !== 1'b1 || if_u.o_beat_cnt !== 3'd0)
        $display("FAIL back_to_back_start: valid=%b busy=%b ready=%b beat=%0d, required 0 1 1 0",
                 if_u.o_c_valid, if_u.o_busy, if_u.o_ready, if_u.o_beat_cnt);
      else n_pass++;
    end else begin
      if (if_u.o_c_valid !== 1'b0 || if_s.o_c_valid !== 1'b0 || if_u.o_busy !== 1'b0)
        $display("FAIL release: valid=%b busy=%b, required 0 0", if_u.o_c_valid, if_u.o_busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (if_u.o_ready !== 1'b0 || if_u.o_busy !== 1'b0 || if_u.o_c_valid !== 1'b0 ||
        if_u.o_beat_cnt !== 3'd0 || if_u.o_c_full !== '0 || if_s.o_c_full !== '0 || if_s.o_busy !== 1'b0)
      $display("FAIL reset_state: ready=%b busy=%b valid=%b beat=%0d c=%h, required all zero",
               if_u.o_ready, if_u.o_busy, if_u.o_c_valid, if_u.o_beat_cnt, if_u.o_c_full);
    else n_pass++;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    logic [O_BITS-1:0] e;
    fill_identity();
    run_job(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    e = if_u.o_c_full[(1*SIZE+2)*O_BITS +: O_BITS];
    n_checks++;
    if (e !== 19'd7) $display("FAIL identity_c12: got %0d, required 7", e);
    else n_pass++;
  endtask

  task automatic test_all_ones();
    logic [O_BITS-1:0] e;
    fill_const(8'hFF, 8'hFF);
    run_job(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    e = if_u.o_c_full[(3*SIZE+3)*O_BITS +: O_BITS];
    n_checks++;
    if (e !== 19'd260100) $display("FAIL all_255_c33: got %0d, required 260100", e);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    fill_identity();
    run_job(1'b0, 1'b0, 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_signed();
    logic [O_BITS-1:0] e;
    fill_const(8'h80, 8'h80);
    run_job(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    e = if_s.o_c_full[0 +: O_BITS];
    n_checks++;
    if (e !== 19'd65536) $display("FAIL signed_neg128_c00: got %0d, required 65536", e);
    else n_pass++;
    fill_const(8'h7F, 8'h80);
    run_job(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    e = if_s.o_c_full[(2*SIZE+1)*O_BITS +: O_BITS];
    n_checks++;
    if (e !== 19'h70200) $display("FAIL signed_mixed_c21: got %h, required 70200", e);
    else n_pass++;
  endtask

  task automatic test_accumulate();
    logic [O_BITS-1:0] e;
    int seen;
    fill_identity();
    run_job(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_job(1'b1, 1'b0, 0, 1, 1'b1, 1'b0);
    e = if_u.o_c_full[(3*SIZE+0)*O_BITS +: O_BITS];
    n_checks++;
    if (e !== 19'd26) $display("FAIL accumulate_c30: got %0d, required 26", e);
    else n_pass++;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (if_u.o_busy !== 1'b0 || if_u.o_c_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL drain_start_ignored: %0d active cycles after release, required 0", seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_job(1'b0, 1'b0, 2, 1, 1'b0, 1'b1);
    fill_random();
    run_job(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int seen;
    fill_random();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid = 1'b1;
      for (int i = 0; i < SIZE; i++) begin
        a_full[i*I_BITS +: I_BITS] = mat_a[i][k];
        b_full[i*I_BITS +: I_BITS] = mat_b[k][i];
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (if_u.o_ready !== 1'b0 || if_u.o_beat_cnt !== 3'd0 || if_u.o_c_valid !== 1'b0 ||
        if_u.o_busy !== 1'b0 || if_u.o_c_full !== '0)
      $display("FAIL abort_state: ready=%b beat=%0d valid=%b busy=%b, required 0 0 0 0",
               if_u.o_ready, if_u.o_beat_cnt, if_u.o_c_valid, if_u.o_busy);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (if_u.o_c_valid !== 1'b0 || if_u.o_busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL abort_no_result: %0d active cycles, required 0", seen);
    else n_pass++;
    fill_random();
    run_job(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    repeat (6) begin
      fill_random();
      run_job(bit'($urandom_range(0, 1)), 1'b0, 2, $urandom_range(0, 3), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_ones();
    test_bubbles();
    test_signed();
    test_accumulate();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
